// File: rtl/vmx_pkg.sv
// Shared types, constants and the per-lane requantizer for the result drain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, accumulator/output lane widths, saturation
// bounds, status word field offsets, requant() helper.
package vmx_pkg;

   localparam int PORT_W = 16;            // output lane width
   localparam int ACC_W  = 2 * PORT_W;    // accumulator lane width

   // Saturation bounds, held at ACC_W+1 bits so they compare directly
   // against the widened rounding result.
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(PORT_W-1) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(PORT_W-1)));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   // status = {drop_cnt[15:0], tile_cnt[11:0], overflow, 1'b0, state[1:0]}
   localparam int ST_STATE_LSB = 0;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_TILE_LSB  = 4;
   localparam int ST_DROP_LSB  = 16;

   // Round-half-up, arithmetic right shift, saturate to PORT_W bits.
   // The bias is added in ACC_W+1 bits so +max accumulators cannot wrap.
   function automatic logic [PORT_W-1:0] requant(input logic signed [ACC_W-1:0] x,
                                                 input logic [4:0]               shift);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] bias;
      logic signed [ACC_W:0] sum;
      logic signed [ACC_W:0] res;
      ext  = {x[ACC_W-1], x};
      bias = '0;
      sum  = ext;
      if (shift != 5'd0) begin
         bias[shift - 5'd1] = 1'b1;
         sum = (ext + bias) >>> shift;
      end
      if (sum > SAT_MAX)
         res = SAT_MAX;
      else if (sum < SAT_MIN)
         res = SAT_MIN;
      else
         res = sum;
      return res[PORT_W-1:0];
   endfunction

endpackage

// File: rtl/vmx_sync_fifo.sv
// Generic show-ahead synchronous FIFO with soft clear.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
//
// Ports: clk, rst_n (async low), clear (sync flush), push/push_dat,
//        pop/pop_dat (head word, valid while !empty), full, empty.
module vmx_sync_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 8      // power of two, >= 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // Extra pointer MSB distinguishes full from empty.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   // A simultaneous pop frees the slot, so push while full is accepted then.
   assign push_ok = push & (~full | pop_ok);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is not reset; the read side is qualified by empty.
   always_ff @(posedge clk) begin
      if (push_ok && !clear)
         mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/vmx_result_drain.sv
// Requantizes MM-wrapper export beats and streams them out with run-end last flags.
// Latency: beat captured at edge E0 is pushed at E1; m_valid high after E1.
// Backpressure: m_ready stalls the FIFO; pushes into a full FIFO are dropped and counted.
//
// Ports: clk, rst_n (async low); wr_en/addr/d_in/shift/relu beat input; clear sync flush;
//        m_data/m_valid/m_last/m_ready output stream; run_addr, status observation.
// Build option: define VMX_RELU_EN to build the ReLU clamp (relu port ignored otherwise).
module vmx_result_drain
   import vmx_pkg::*;
#(
   parameter int PE_SIZE    = 4,
   parameter int PORT_WIDTH = PORT_W,   // must equal vmx_pkg::PORT_W
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_en,
   input  logic [7:0]                      addr,
   input  logic [2*PORT_WIDTH*PE_SIZE-1:0] d_in,
   input  logic [4:0]                      shift,
   input  logic                            clear,
   input  logic                            relu,
   output logic [PORT_WIDTH*PE_SIZE-1:0]   m_data,
   output logic                            m_valid,
   output logic                            m_last,
   input  logic                            m_ready,
   output logic [7:0]                      run_addr,
   output logic [31:0]                     status
);

   localparam int OUT_W = PORT_WIDTH * PE_SIZE;

   logic [OUT_W-1:0] beat_q;
   logic             hold_vld;
   logic [OUT_W-1:0] hold_dat;
   logic             fifo_push;
   logic [OUT_W:0]   fifo_dat;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             drop;
   logic             overflow;
   logic [15:0]      drop_cnt;
   logic [11:0]      tile_cnt;
   state_e           state_q;
   state_e           state_d;
   logic             latch_addr;

   always_comb begin
      logic [PORT_WIDTH-1:0] lane;
      beat_q = '0;
      lane   = '0;
      for (int k = 0; k < PE_SIZE; k++) begin
         lane = requant(d_in[k*ACC_W +: ACC_W], shift);
`ifdef VMX_RELU_EN
         if (relu && lane[PORT_WIDTH-1])
            lane = '0;
`endif
         beat_q[k*PORT_WIDTH +: PORT_WIDTH] = lane;
      end
   end

`ifndef VMX_RELU_EN
   logic unused_relu;
   assign unused_relu = relu;
`endif

   // The held beat is pushed on every edge it is valid; whether it ends the
   // run is only known now, from the current wr_en.
   assign fifo_push = hold_vld & ~clear;
   assign pop       = ~fifo_empty & m_ready;
   assign drop      = fifo_push & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld <= 1'b0;
         hold_dat <= '0;
      end else if (clear) begin
         hold_vld <= 1'b0;
         hold_dat <= '0;
      end else if (wr_en) begin
         hold_vld <= 1'b1;
         hold_dat <= beat_q;
      end else begin
         hold_vld <= 1'b0;
      end
   end

   vmx_sync_fifo #(.W(OUT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (fifo_push),
      .push_dat ({~wr_en, hold_dat}),
      .pop      (pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Gate the head word so idle/reset outputs read as zero.
   assign m_valid = ~fifo_empty;
   assign m_data  = fifo_empty ? '0 : fifo_dat[OUT_W-1:0];
   assign m_last  = ~fifo_empty & fifo_dat[OUT_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         tile_cnt <= '0;
      end else if (clear) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         tile_cnt <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end
         if (pop && m_last)
            tile_cnt <= tile_cnt + 12'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      latch_addr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_en) begin
               state_d    = S_RUN;
               latch_addr = 1'b1;
            end
         end
         S_RUN: begin
            if (!wr_en)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // A new run may start before the previous one has drained.
            if (wr_en) begin
               state_d    = S_RUN;
               latch_addr = 1'b1;
            end else if (fifo_empty && !hold_vld) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         run_addr <= '0;
      end else if (clear) begin
         state_q  <= S_IDLE;
         run_addr <= '0;
      end else begin
         state_q <= state_d;
         if (latch_addr)
            run_addr <= addr;
      end
   end

   always_comb begin
      status = '0;
      status[ST_STATE_LSB +: 2] = state_q;
      status[ST_OVF_BIT]        = overflow;
      status[ST_TILE_LSB +: 12] = tile_cnt;
      status[ST_DROP_LSB +: 16] = drop_cnt;
   end

endmodule
